avmm_copy_master: RTL and testbench

//   Avalon-MM master (initiator) copy engine: reads len_words 32-bit words from src_addr and writes them to dst_addr.

---
 rtl/avmm_copy_master.sv | 238 +++++++++++++++++++++++
 tb/tb_avmm_copy_master.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_copy_master.sv
// avm copy engine: Avalon-MM master that copies len_words 32-bit words
// from src_addr to dst_addr in FIFO-sized read/write batches.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   start               one-cycle request, sampled only while idle
//   src_addr, dst_addr  byte addresses (low two bits ignored)
//   len_words           number of words to copy (0 allowed)
//   busy, done          status; done pulses for one cycle at completion
//   avm_*               Avalon-MM master command/response signals
//   checksum            sum of written words (AVMM_COPY_CHECKSUM_EN only)
//
// Optional feature macro: AVMM_COPY_CHECKSUM_EN
module avmm_copy_master #(
    parameter int ADDR_W     = 15,
    parameter int LEN_W      = 13,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest
`ifdef AVMM_COPY_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [LEN_W-1:0]  DEPTH_L = LEN_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  batch_q, batch_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  received_q, received_d;
    logic [CNT_W-1:0]  written_q, written_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

    logic [31:0] fifo_mem_q [FIFO_DEPTH];

    logic rd_acc;
    logic wr_acc;
    logic capture;

    function automatic logic [CNT_W-1:0] batch_of(
        input logic [LEN_W-1:0] rem
    );
        if (rem >= DEPTH_L) begin
            return DEPTH_C;
        end
        return rem[CNT_W-1:0];
    endfunction

    assign rd_acc = avm_read & ~avm_waitrequest;
    assign wr_acc = avm_write & ~avm_waitrequest;

    // Only responses to reads of the current batch are kept; anything
    // arriving with no read outstanding (e.g. after a reset) is dropped.
    assign capture = avm_readdatavalid
                   & (state_q != S_IDLE)
                   & (issued_q != received_q);

    assign avm_byteenable = 4'hF;
    assign avm_writedata  = fifo_mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rem_d      = rem_q;
        batch_d    = batch_q;
        issued_d   = issued_q;
        received_d = received_q;
        written_d  = written_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        avm_read    = 1'b0;
        avm_write   = 1'b0;
        avm_address = '0;
        busy        = (state_q != S_IDLE);
        done        = 1'b0;

        if (capture) begin
            received_d = received_q + CNT_W'(1);
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d      = src_addr & WORD_MASK;
                    dst_d      = dst_addr & WORD_MASK;
                    rem_d      = len_words;
                    batch_d    = batch_of(len_words);
                    issued_d   = '0;
                    received_d = '0;
                    written_d  = '0;
                    if (len_words == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                avm_read    = 1'b1;
                avm_address = src_q;
                if (rd_acc) begin
                    src_d    = src_q + WORD_STEP;
                    issued_d = issued_q + CNT_W'(1);
                    if (issued_d == batch_q) begin
                        state_d = S_WAIT_DATA;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (received_q == batch_q) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                avm_write   = 1'b1;
                avm_address = dst_q;
                if (wr_acc) begin
                    dst_d     = dst_q + WORD_STEP;
                    rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                    written_d = written_q + CNT_W'(1);
                    if (written_d == batch_q) begin
                        rem_d      = rem_q - LEN_W'(batch_q);
                        batch_d    = batch_of(rem_d);
                        issued_d   = '0;
                        received_d = '0;
                        written_d  = '0;
                        if (rem_d == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            batch_q    <= '0;
            issued_q   <= '0;
            received_q <= '0;
            written_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rem_q      <= rem_d;
            batch_q    <= batch_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            written_q  <= written_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (capture) begin
            fifo_mem_q[wr_ptr_q] <= avm_readdata;
        end
    end

`ifdef AVMM_COPY_CHECKSUM_EN
    logic [31:0] ck_q, ck_d;

    always_comb begin
        ck_d = ck_q;
        if ((state_q == S_IDLE) && start) begin
            ck_d = '0;
        end else if (wr_acc) begin
            ck_d = ck_q + avm_writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ck_q <= '0;
        end else begin
            ck_q <= ck_d;
        end
    end

    assign checksum = ck_q;
`endif

endmodule

// File: tb/tb_avmm_copy_master.sv
// Bench for avmm_copy_master: RAM slave model plus a scoreboard monitor
// comparing every accepted read/write and each done pulse.
module tb_avmm_copy_master;

    localparam int ADDR_W = 15;
    localparam int LEN_W  = 13;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src_addr = '0;
    logic [ADDR_W-1:0] dst_addr = '0;
    logic [LEN_W-1:0]  len_words = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;
    logic              avm_waitrequest;
`ifdef AVMM_COPY_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    avmm_copy_master dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .src_addr          (src_addr),
        .dst_addr          (dst_addr),
        .len_words         (len_words),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest)
`ifdef AVMM_COPY_CHECKSUM_EN
        ,
        .checksum          (checksum)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 32'h100) return 32'hFFFF_FFFF;
        if (i == 32'h101) return 32'h0000_0002;
        return 32'hA500_0000 | 32'(i);
    endfunction

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic [31:0] d;
        longint      due;
    } rsp_t;

    logic [31:0]       mem  [8192];
    logic [31:0]       gold [8192];
    logic [ADDR_W-1:0] exp_rd [$];
    wr_t               exp_wr [$];
    logic [31:0]       exp_done [$];
    int                obs_batches [$];

    int  lat = 1;
    bit  rand_wait = 1'b0;
    bit  inject = 1'b0;

    // RAM slave: pipelined, in-order responses after `lat` cycles.
    initial begin
        longint cyc;
        rsp_t   r;
        rsp_t   rq [$];
        cyc = 0;
        avm_readdata = '0;
        avm_readdatavalid = 1'b0;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            avm_readdatavalid <= 1'b0;
            avm_readdata <= '0;
            if (avm_read && !avm_waitrequest) begin
                r.d = mem[avm_address[ADDR_W-1:2]];
                r.due = cyc + lat - 1;
                rq.push_back(r);
            end
            if (avm_write && !avm_waitrequest)
                mem[avm_address[ADDR_W-1:2]] <= avm_writedata;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                r = rq.pop_front();
                avm_readdatavalid <= 1'b1;
                avm_readdata <= r.d;
            end else if (inject) begin
                avm_readdatavalid <= 1'b1;
                avm_readdata <= 32'hDEAD_BEEF;
            end
            avm_waitrequest <= rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc++;
        end
    end

    bit                stall_prev = 1'b0;
    logic [48:0]       prev_cmd;
    int                run_len = 0;
    bit                last_was_write = 1'b1;

    // Monitor: sampled mid-cycle, pops expectations on each acceptance.
    initial begin
        logic [48:0] cur;
        wr_t         w;
        logic [31:0] ck;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_prev = 1'b0;
            end else begin
                cur = {avm_read, avm_write, avm_address,
                       avm_write ? avm_writedata : 32'h0};
                if (avm_read || avm_write)
                    chk("rd_wr_excl", {avm_read, avm_write} == 2'b11, 0);
                if (stall_prev)
                    chk("stall_hold", cur, prev_cmd);
                stall_prev = (avm_read || avm_write) && avm_waitrequest;
                prev_cmd = cur;
                if (avm_read && !avm_waitrequest) begin
                    if (last_was_write) begin
                        run_len = 0;
                        last_was_write = 1'b0;
                    end
                    run_len++;
                    if (exp_rd.size() == 0) begin
                        chk("rd_unexpected", avm_address, 'x);
                    end else begin
                        chk("rd_addr", avm_address, exp_rd.pop_front());
                    end
                end
                if (avm_write && !avm_waitrequest) begin
                    if (!last_was_write) begin
                        obs_batches.push_back(run_len);
                        last_was_write = 1'b1;
                    end
                    if (exp_wr.size() == 0) begin
                        chk("wr_unexpected", avm_address, 'x);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("wr_addr", avm_address, w.addr);
                        chk("wr_data", avm_writedata, w.data);
                    end
                end
                if (done) begin
                    chk("busy_in_done", busy, 1);
                    if (exp_done.size() == 0) begin
                        chk("done_unexpected", done, 0);
                    end else begin
                        ck = exp_done.pop_front();
`ifdef AVMM_COPY_CHECKSUM_EN
                        chk("checksum", checksum, ck);
`endif
                    end
                end
            end
        end
    end

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        reset_n = 1'b1;
    endtask

    // Push the full expected transaction stream, then pulse start.
    task automatic start_copy(input logic [ADDR_W-1:0] src,
                              input logic [ADDR_W-1:0] dst,
                              input int len);
        logic [ADDR_W-1:0] ra, wa;
        logic [31:0]       sum;
        wr_t               w;
        sum = '0;
        for (int k = 0; k < len; k++) begin
            ra = (src & 15'h7FFC) + ADDR_W'(4 * k);
            wa = (dst & 15'h7FFC) + ADDR_W'(4 * k);
            exp_rd.push_back(ra);
            w.addr = wa;
            w.data = gold[ra[ADDR_W-1:2]];
            exp_wr.push_back(w);
            sum += w.data;
            gold[wa[ADDR_W-1:2]] = w.data;
        end
        exp_done.push_back(sum);
        src_addr = src;
        dst_addr = dst;
        len_words = LEN_W'(len);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int dc, output int fr, output int fw);
        int n;
        dc = -1;
        fr = -1;
        fw = -1;
        for (n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (avm_read && fr < 0) fr = n;
            if (avm_write && fw < 0) fw = n;
            if (done) begin
                dc = n;
                break;
            end
        end
        if (dc < 0) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_single", done, 0);
        chk("busy_after", busy, 0);
        chk("rd_left", exp_rd.size(), 0);
        chk("wr_left", exp_wr.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int dc, fr, fw, n;
        int exp_b [3];
        exp_b = '{8, 8, 4};
        for (int i = 0; i < 8192; i++) gold[i] = init_word(i);

        // 1: reset values, 4-word copy, read latency from start
        do_reset(3);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_write", avm_write, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_be", avm_byteenable, 4'hF);
        @(posedge clk);
        #1;
        obs_batches.delete();
        last_was_write = 1'b1;
        start_copy(15'h0000, 15'h1000, 4);
        wait_done(dc, fr, fw);
        chk("t1_first_read", fr, 1);
        chk("t1_batches", obs_batches.size(), 1);
        if (obs_batches.size() > 0) chk("t1_batch0", obs_batches[0], 4);

        // 1b: single word, zero wait, latency 1
        start_copy(15'h0040, 15'h1400, 1);
        wait_done(dc, fr, fw);
        chk("t1b_done_lat", dc, 5);

        // 2: zero-length copy
        start_copy(15'h0080, 15'h1800, 0);
        wait_done(dc, fr, fw);
        chk("t2_done_lat", dc, 1);
        chk("t2_no_read", fr, -1);
        chk("t2_no_write", fw, -1);

        // 3: three batches 8, 8, 4
        obs_batches.delete();
        last_was_write = 1'b1;
        start_copy(15'h0200, 15'h2000, 20);
        wait_done(dc, fr, fw);
        chk("t3_nbatch", obs_batches.size(), 3);
        for (int i = 0; i < 3 && i < obs_batches.size(); i++)
            chk("t3_batch", obs_batches[i], exp_b[i]);

        // 4: random stalls, latency 3, unaligned inputs
        rand_wait = 1'b1;
        lat = 3;
        start_copy(15'h0602, 15'h2801, 10);
        wait_done(dc, fr, fw);
        rand_wait = 1'b0;

        // 5: reset during first write batch, then during reads
        lat = 1;
        start_copy(15'h0800, 15'h3000, 16);
        n = 0;
        while (n < 500) begin
            @(negedge clk);
            if (avm_write) break;
            n++;
        end
        chk("t5_write_seen", n < 500, 1);
        @(posedge clk);
        #1;
        do_reset(4);
        lat = 3;
        start_copy(15'h0A00, 15'h3200, 8);
        n = 0;
        while (n < 500) begin
            @(negedge clk);
            if (avm_read && !avm_waitrequest) n += 1000;
            n++;
        end
        @(posedge clk);
        #1;
        do_reset(1);
        repeat (6) @(posedge clk);
        #1;
        inject = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        inject = 1'b0;
        start_copy(15'h0900, 15'h3400, 2);
        wait_done(dc, fr, fw);

        // 6: checksum wraparound and source address wrap
        lat = 1;
        start_copy(15'h0400, 15'h3800, 2);
        wait_done(dc, fr, fw);
`ifdef AVMM_COPY_CHECKSUM_EN
        chk("t6_ck_hold", checksum, 32'h0000_0001);
`endif
        start_copy(15'h7FFC, 15'h3C00, 2);
        wait_done(dc, fr, fw);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
